// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller: forwarding selects,
// controller states and the default register-address width.
package pipe_ctrl_pkg;

  localparam int RA_W_DEFAULT = 5;

  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10
  } fwd_sel_t;

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    LDSTALL = 2'b01,
    MEMWAIT = 2'b10
  } ctrl_state_t;

endpackage

// File: rtl/pipe_stage_tracker.sv
// Shadow copy of the EX/MEM/WB destination fields plus the EX operand
// forwarding compare derived from them.
module pipe_stage_tracker
  import pipe_ctrl_pkg::*;
#(
  parameter int RA_W = RA_W_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            advance,
  input  logic            bubble,
  input  logic            id_valid,
  input  logic [RA_W-1:0] id_rs,
  input  logic [RA_W-1:0] id_rt,
  input  logic [RA_W-1:0] id_rw,
  input  logic            id_regwrite,
  input  logic            id_memread,
  output logic            ex_valid,
  output logic [RA_W-1:0] ex_rw,
  output logic            ex_regwrite,
  output logic            ex_memread,
  output logic            mem_valid,
  output logic [1:0]      fwd_a,
  output logic [1:0]      fwd_b
);

  logic [RA_W-1:0] ex_rs;
  logic [RA_W-1:0] ex_rt;
  logic [RA_W-1:0] mem_rw;
  logic            mem_regwrite;
  logic            wb_valid;
  logic [RA_W-1:0] wb_rw;
  logic            wb_regwrite;
  logic            mem_src_ok;
  logic            wb_src_ok;
  fwd_sel_t        sel_a;
  fwd_sel_t        sel_b;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_valid     <= 1'b0;
      ex_rs        <= '0;
      ex_rt        <= '0;
      ex_rw        <= '0;
      ex_regwrite  <= 1'b0;
      ex_memread   <= 1'b0;
      mem_valid    <= 1'b0;
      mem_rw       <= '0;
      mem_regwrite <= 1'b0;
      wb_valid     <= 1'b0;
      wb_rw        <= '0;
      wb_regwrite  <= 1'b0;
    end else if (advance) begin
      wb_valid     <= mem_valid;
      wb_rw        <= mem_rw;
      wb_regwrite  <= mem_regwrite;
      mem_valid    <= ex_valid;
      mem_rw       <= ex_rw;
      mem_regwrite <= ex_regwrite;
      // Bubbles carry zeroed fields so stale source numbers never forward.
      if (bubble) begin
        ex_valid    <= 1'b0;
        ex_rs       <= '0;
        ex_rt       <= '0;
        ex_rw       <= '0;
        ex_regwrite <= 1'b0;
        ex_memread  <= 1'b0;
      end else begin
        ex_valid    <= id_valid;
        ex_rs       <= id_rs;
        ex_rt       <= id_rt;
        ex_rw       <= id_rw;
        ex_regwrite <= id_regwrite;
        ex_memread  <= id_memread;
      end
    end
  end

  assign mem_src_ok = mem_valid & mem_regwrite & (mem_rw != '0);
  assign wb_src_ok  = wb_valid & wb_regwrite & (wb_rw != '0);

  always_comb begin
    sel_a = FWD_RF;
    sel_b = FWD_RF;
    if (mem_src_ok && (mem_rw == ex_rs))     sel_a = FWD_EXMEM;
    else if (wb_src_ok && (wb_rw == ex_rs))  sel_a = FWD_MEMWB;
    if (mem_src_ok && (mem_rw == ex_rt))     sel_b = FWD_EXMEM;
    else if (wb_src_ok && (wb_rw == ex_rt))  sel_b = FWD_MEMWB;
  end

  assign fwd_a = sel_a;
  assign fwd_b = sel_b;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage pipeline: stall, flush and
// freeze decisions, controller state, statistics and memory-wait watchdog.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int RA_W     = RA_W_DEFAULT,
  parameter int CNT_W    = 16,
  parameter int MAX_WAIT = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [RA_W-1:0]  id_rs,
  input  logic [RA_W-1:0]  id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic [RA_W-1:0]  id_rw,
  input  logic             id_regwrite,
  input  logic             id_memread,
  input  logic             ex_redirect,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             pipe_en,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             wait_err
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  logic            ex_valid;
  logic [RA_W-1:0] ex_rw;
  logic            ex_regwrite;
  logic            ex_memread;
  logic            mem_valid;
  logic            freeze;
  logic            redirect;
  logic            load_use;
  ctrl_state_t     cur_state;
  logic [WAIT_W-1:0] wait_cnt;

  pipe_stage_tracker #(.RA_W(RA_W)) u_tracker (
    .clk         (clk),
    .reset       (reset),
    .advance     (~freeze),
    .bubble      (redirect | load_use),
    .id_valid    (id_valid),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_rw       (id_rw),
    .id_regwrite (id_regwrite),
    .id_memread  (id_memread),
    .ex_valid    (ex_valid),
    .ex_rw       (ex_rw),
    .ex_regwrite (ex_regwrite),
    .ex_memread  (ex_memread),
    .mem_valid   (mem_valid),
    .fwd_a       (fwd_a),
    .fwd_b       (fwd_b)
  );

  assign freeze   = mem_valid & mem_req & ~mem_ready;
  assign redirect = ex_valid & ex_redirect;
  assign load_use = id_valid & ex_valid & ex_memread & ex_regwrite & (ex_rw != '0) &
                    ((id_uses_rs & (id_rs == ex_rw)) | (id_uses_rt & (id_rt == ex_rw)));

  always_comb begin
    pc_en      = 1'b1;
    ifid_en    = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    pipe_en    = 1'b1;
    if (freeze) begin
      pc_en   = 1'b0;
      ifid_en = 1'b0;
      pipe_en = 1'b0;
    end else if (redirect) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (load_use) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur_state <= RUN;
      stall_cnt <= '0;
      flush_cnt <= '0;
      wait_cnt  <= '0;
      wait_err  <= 1'b0;
    end else begin
      case (cur_state)
        RUN:     if (freeze) cur_state <= MEMWAIT;
                 else if (load_use && !redirect) cur_state <= LDSTALL;
        LDSTALL: cur_state <= freeze ? MEMWAIT : RUN;
        MEMWAIT: if (!freeze) cur_state <= RUN;
        default: cur_state <= RUN;
      endcase

      if (!pc_en && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
      if (redirect && !freeze && (flush_cnt != '1)) flush_cnt <= flush_cnt + 1'b1;

      // The error flags the wait but never unfreezes; only reset clears it.
      if (freeze) begin
        if (wait_cnt != WAIT_W'(MAX_WAIT)) wait_cnt <= wait_cnt + 1'b1;
        if (wait_cnt == WAIT_W'(MAX_WAIT - 1)) wait_err <= 1'b1;
      end else begin
        wait_cnt <= '0;
      end
    end
  end

  assign state = cur_state;

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Hazard and sequencing controller for the 5-stage MIPS pipeline (IF/ID/EX/MEM/WB) on the CPU clock.
- Keeps its own shadow copy of in-flight register destinations.
- Generates PC / IF-ID enables, IF-ID and ID-EX flushes, and EX operand forwarding selects.
- Freezes the whole pipeline while the data memory handshake is pending.
- Keeps stall and flush statistics, and raises a sticky watchdog error when a memory wait exceeds its limit.

Parameters:
- RA_W, 5, register address width.
- CNT_W, 16, width of the statistics counters (saturating).
- MAX_WAIT, 64, memory wait cycles before wait_err is set.

Ports:
- clk  in  1  CPU pipeline clock.
- reset  in  1  asynchronous, active-low reset.
- id_valid  in  1  ID stage holds a real instruction.
- id_rs  in  RA_W  ID source register 1.
- id_rt  in  RA_W  ID source register 2.
- id_uses_rs  in  1  ID instruction reads rs.
- id_uses_rt  in  1  ID instruction reads rt.
- id_rw  in  RA_W  ID destination register (already muxed by RegDst).
- id_regwrite  in  1  ID instruction writes the register file.
- id_memread  in  1  ID instruction is a load.
- ex_redirect  in  1  EX resolved a taken branch, jump or jr.
- mem_req  in  1  MEM stage is accessing data memory.
- mem_ready  in  1  data memory completes the access this cycle.
- pc_en  out  1  PC register load enable.
- ifid_en  out  1  IF/ID register load enable.
- ifid_flush  out  1  load a NOP into IF/ID.
- idex_flush  out  1  load a bubble into ID/EX.
- pipe_en  out  1  EX/MEM and MEM/WB load enable.
- fwd_a  out  2  EX operand A select: 00 register file, 01 EX/MEM, 10 MEM/WB.
- fwd_b  out  2  EX operand B select, same encoding as fwd_a.
- state  out  2  00 RUN, 01 LDSTALL, 10 MEMWAIT.
- stall_cnt  out  CNT_W  cycles with pc_en=0.
- flush_cnt  out  CNT_W  number of accepted redirects.
- wait_err  out  1  sticky memory-wait timeout flag.

Behaviour:
- Reset (reset=0, asynchronous):
  - All shadow stage registers cleared; state=RUN; counters and wait_err cleared.
  - Outputs during reset: pc_en=ifid_en=pipe_en=1, flushes=0, fwd=00.
- Shadow stages: ex{valid,rs,rt,rw,regwrite,memread}, mem{valid,rw,regwrite,memread}, wb{valid,rw,regwrite}.
- A destination rw=0 never matches any source register.
- freeze = mem_valid & mem_req & !mem_ready.
- redirect = ex_valid & ex_redirect.
- load_use = id_valid & ex_valid & ex_memread & ex_regwrite & ex_rw!=0 & ((id_uses_rs & id_rs==ex_rw) | (id_uses_rt & id_rt==ex_rw)).
- Priority: freeze > redirect > load_use.
  - Freeze: all enables 0, all flushes 0, shadow stages hold.
  - Redirect: pc_en=1, ifid_en=1, ifid_flush=1, idex_flush=1; load_use is ignored.
  - Load-use: pc_en=0, ifid_en=0, idex_flush=1.
  - Otherwise: all enables 1, all flushes 0.
- Shadow advance when not frozen:
  - wb<=mem, mem<=ex.
  - ex<=bubble (valid=0) if redirect|load_use, else ex<=ID fields with valid=id_valid.
- Forwarding (combinational from shadow registers, also valid while frozen):
  - fwd_a=01 if mem_valid & mem_regwrite & mem_rw!=0 & mem_rw==ex_rs.
  - Else fwd_a=10 if the same condition holds with the wb fields.
  - Else fwd_a=00.
  - fwd_b is identical using ex_rt.
  - EX/MEM has precedence over MEM/WB.
- FSM (registered, state reflects the previous cycle's decision):
  - RUN -> MEMWAIT on freeze.
  - RUN -> LDSTALL on load_use & !redirect.
  - LDSTALL -> RUN (one cycle; the bubble guarantees the consumer then reaches EX and forwards from MEM/WB).
  - MEMWAIT -> RUN when mem_ready=1.
- Wait counter:
  - Counts consecutive frozen cycles; clears on exit from MEMWAIT.
  - On reaching MAX_WAIT, wait_err<=1 (sticky until reset); the pipeline stays frozen.
- Counters: stall_cnt increments when pc_en=0; flush_cnt increments on redirect when not frozen. Both saturate at all-ones.
- Reset asserted mid-wait or mid-stall: immediate return to RUN with empty shadow stages.

Decomposition:
- Package pipe_ctrl_pkg: FWD_RF/FWD_EXMEM/FWD_MEMWB encodings, state encodings (RUN/LDSTALL/MEMWAIT), RA_W default.
- One sub-module, pipe_stage_tracker: shadow stage shift registers plus the forwarding compare.
- Top level holds the FSM, priority logic and counters.

Test Plan:
1. lw $8 in EX, ID add uses rs=8 -> one cycle pc_en=0, idex_flush=1, state=LDSTALL; two cycles later fwd_a=10; stall_cnt=1.
2. ID regwrite rw=9, then next instruction reads rt=9 -> fwd_b=01; a third instruction also writing 9 keeps 01 (EX/MEM precedence); rw=0 writer with a reader of 0 -> fwd=00.
3. ex_redirect=1 in the same cycle as load_use -> pc_en=1, ifid_flush=1, idex_flush=1, flush_cnt=1, stall_cnt unchanged.
4. mem_req=1 with mem_ready low for 3 cycles -> pc_en=pipe_en=0 for 3 cycles, state=MEMWAIT, shadow stages and fwd hold, stall_cnt=3; resume on ready.
5. mem_ready held low for MAX_WAIT=64 cycles -> wait_err=1 at cycle 64 and stays 1 after ready rises; drop reset low -> wait_err=0, state=RUN.
6. Reset asserted during LDSTALL, release, then feed an independent instruction stream -> no stalls and fwd=00 throughout.
